// File: rtl/bin_display_rx.sv
// Receiver for the divider's slow toggle + 4-bit count: synchronises both, captures
// each new value onto LEDs, shows it as decimal 00-15 on a 2-digit scanned display.
module bin_display_rx #(
    parameter int REFRESH_DIV    = 50000,
    parameter int STALE_CYCLES   = 400000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tog_in,
    input  logic [3:0] num_in,
    output logic [3:0] led,
    output logic       upd_pulse,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       stale
);

    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] AN_OFF  = {2{SEG_ACTIVE_LOW}};

    typedef enum logic {DIG0, DIG1} scan_state_t;

    scan_state_t   state_reg, state_next;
    logic [RW-1:0] refresh_cnt_reg, refresh_cnt_next;
    logic [SW-1:0] stale_cnt_reg, stale_cnt_next;
    logic          tog_s1_reg, tog_s2_reg, tog_s3_reg;
    logic [3:0]    num_n1_reg, num_n2_reg;
    logic          primed_reg, primed_next;
    logic [1:0]    prime_cnt_reg, prime_cnt_next;
    logic [3:0]    led_reg, led_next;
    logic          upd_pulse_reg, upd_pulse_next;
    logic [6:0]    seg_reg, seg_next;
    logic [1:0]    an_reg, an_next;

    logic       upd;
    logic [3:0] units;
    logic       tens_nz;
    logic [6:0] tens_pat, seg_raw;
    logic [1:0] an_raw;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= DIG0;
            refresh_cnt_reg <= '0;
            stale_cnt_reg   <= '0;
            tog_s1_reg      <= 1'b0;
            tog_s2_reg      <= 1'b0;
            tog_s3_reg      <= 1'b0;
            num_n1_reg      <= 4'd0;
            num_n2_reg      <= 4'd0;
            primed_reg      <= 1'b0;
            prime_cnt_reg   <= 2'd0;
            led_reg         <= 4'd0;
            upd_pulse_reg   <= 1'b0;
            seg_reg         <= SEG_OFF;
            an_reg          <= AN_OFF;
        end else begin
            state_reg       <= state_next;
            refresh_cnt_reg <= refresh_cnt_next;
            stale_cnt_reg   <= stale_cnt_next;
            tog_s1_reg      <= tog_in;
            tog_s2_reg      <= tog_s1_reg;
            tog_s3_reg      <= tog_s2_reg;
            num_n1_reg      <= num_in;
            num_n2_reg      <= num_n1_reg;
            primed_reg      <= primed_next;
            prime_cnt_reg   <= prime_cnt_next;
            led_reg         <= led_next;
            upd_pulse_reg   <= upd_pulse_next;
            seg_reg         <= seg_next;
            an_reg          <= an_next;
        end
    end

    // Capture path: priming load, toggle-driven updates and the saturating stale counter.
    always_comb begin
        primed_next    = primed_reg;
        prime_cnt_next = prime_cnt_reg;
        led_next       = led_reg;
        upd_pulse_next = 1'b0;
        stale_cnt_next = stale_cnt_reg;
        upd            = primed_reg && (tog_s2_reg != tog_s3_reg);

        if (!primed_reg) begin
            if (prime_cnt_reg == 2'd2) begin
                primed_next    = 1'b1;
                led_next       = num_n2_reg;
                stale_cnt_next = '0;
            end else begin
                prime_cnt_next = prime_cnt_reg + 2'd1;
            end
        end else if (upd) begin
            led_next       = num_n2_reg;
            upd_pulse_next = 1'b1;
            stale_cnt_next = '0;
        end else if (stale_cnt_reg != SW'(STALE_CYCLES)) begin
            stale_cnt_next = stale_cnt_reg + SW'(1);
        end
    end

    // Scan: the wrap edge flips the digit and blanks the anodes for one cycle
    // while seg already loads the incoming digit's pattern.
    always_comb begin
        state_next       = state_reg;
        refresh_cnt_next = refresh_cnt_reg + RW'(1);
        tens_nz          = (led_reg >= 4'd10);
        units            = tens_nz ? (led_reg - 4'd10) : led_reg;
        tens_pat         = (BLANK_LZ && !tens_nz) ? 7'h00 : seg_code({3'b000, tens_nz});

        if (refresh_cnt_reg == RW'(REFRESH_DIV - 1)) begin
            state_next       = (state_reg == DIG0) ? DIG1 : DIG0;
            refresh_cnt_next = '0;
            an_raw           = 2'b00;
        end else begin
            an_raw = (state_reg == DIG0) ? 2'b01 : 2'b10;
        end

        seg_raw  = (state_next == DIG0) ? seg_code(units) : tens_pat;
        seg_next = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_next  = SEG_ACTIVE_LOW ? ~an_raw : an_raw;
    end

    assign led       = led_reg;
    assign upd_pulse = upd_pulse_reg;
    assign seg       = seg_reg;
    assign an        = an_reg;
    assign stale     = (stale_cnt_reg == SW'(STALE_CYCLES));

endmodule

// File: tb/tb_bin_display_rx.sv
// Randomised bench for bin_display_rx: every cycle the outputs are compared with a
// reference model derived from the sample history (latency, decimal split, scan slots).
module tb_bin_display_rx;

    localparam int R = 4;
    localparam int S = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tog_in = 1'b0;
    logic [3:0] num_in = 4'd0;
    logic [3:0] led;
    logic       upd_pulse;
    logic [6:0] seg;
    logic [1:0] an;
    logic       stale;

    bin_display_rx #(
        .REFRESH_DIV(R),
        .STALE_CYCLES(S),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tog_in(tog_in),
        .num_in(num_in),
        .led(led),
        .upd_pulse(upd_pulse),
        .seg(seg),
        .an(an),
        .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: k = edges since reset released, histories indexed by k.
    int   k = 0;
    bit   tog_h[$];
    int   num_h[$];
    int   m_led = 0;
    int   m_pulse = 0;
    int   m_scnt = 0;
    int   m_primed = 0;
    logic tog_cur = 1'b0;
    logic [3:0] num_cur = 4'd0;
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic t, input logic [3:0] n);
        int         led_before;
        int         dig;
        logic [6:0] pat;
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
        rst_n  = rst;
        tog_in = t;
        num_in = n;
        @(posedge clk);
        cyc++;
        led_before = m_led;
        if (!rst) begin
            k = 0;
            tog_h = {1'b0};
            num_h = {0};
            m_led = 0;
            m_pulse = 0;
            m_scnt = 0;
            m_primed = 0;
            exp_seg = 7'h7F;
            exp_an = 2'b11;
        end else begin
            k++;
            tog_h.push_back(t);
            num_h.push_back(int'(n));
            m_pulse = 0;
            if (k == 3) begin
                m_primed = 1;
                m_led = num_h[1];
                m_scnt = 0;
            end else if (k > 3 && tog_h[k-2] != tog_h[k-3]) begin
                m_led = num_h[k-2];
                m_pulse = 1;
                m_scnt = 0;
            end else if (m_primed != 0 && m_scnt < S) begin
                m_scnt++;
            end
            dig = (k / R) % 2;
            if (dig == 0) pat = codes[led_before % 10];
            else pat = (led_before >= 10) ? codes[1] : 7'h00;
            exp_seg = ~pat;
            if (k % R == 0) exp_an = 2'b11;
            else exp_an = (dig == 0) ? 2'b10 : 2'b01;
        end
        #1;
        check_val("led", int'(led), m_led);
        check_val("upd_pulse", int'(upd_pulse), m_pulse);
        check_val("stale", int'(stale), (m_scnt == S) ? 1 : 0);
        check_val("an", int'(an), int'(exp_an));
        check_val("seg", int'(seg), int'(exp_seg));
        $display("cycle %0d rst_n=%0b tog=%0b num=%0d led=%0d upd=%0b stale=%0b an=%b seg=%h",
                 cyc, rst, t, n, led, upd_pulse, stale, an, seg);
    endtask

    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, tog_cur, num_cur);
    endtask

    task automatic send(input logic [3:0] n, input int after);
        num_cur = n;
        hold(3);
        tog_cur = ~tog_cur;
        hold(after);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, tog_cur, num_cur);
    endtask

    initial begin
        // Reset and priming with tog_in already high
        tog_cur = 1'b1;
        num_cur = 4'd5;
        do_reset(3);
        hold(6);
        // Update latency, both toggle polarities
        send(4'd9, 6);
        send(4'd10, 6);
        // Decimal display and leading-zero blanking
        send(4'd13, 12);
        send(4'd7, 12);
        // Stale after silence, then cleared by a toggle
        hold(30);
        send(4'd3, 6);
        // Randomised traffic with occasional mid-operation resets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_reset($urandom_range(1, 3));
                hold(4);
            end
            send(4'($urandom_range(0, 15)), $urandom_range(3, 35));
        end
        // Reset while led=12 and the tens digit is lit
        send(4'd12, 3);
        for (int i = 0; i < 20; i++) begin
            if (((k / R) % 2 == 1) && (k % R != 0)) break;
            hold(1);
        end
        check_val("dig1_lit_before_reset", int'(an), 2'b01);
        num_cur = 4'd6;
        do_reset(1);
        hold(8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
